// File: rtl/heartbeat_seq.sv
// -----------------------------------------------------------------------------
// heartbeat_seq
//   Heartbeat animation sequencer for a 7-segment display. A prescaled tick
//   engine drives a four-state FSM (REST, LUB, GAP, DUB) that produces a
//   lub-dub rhythm. The rate comes from a 4-bit speed select. Pause and
//   single-step controls are provided for bring-up and demos.
//
// Ports
//   clk      in   1  clock
//   rst_n    in   1  asynchronous active-low reset
//   ena      in   1  design selected; low blanks the display and freezes it
//   speed    in   4  rate select, 0 = fastest; tick period (speed+1)<<SHIFT
//   pause    in   1  level; 1 holds the state and the prescaler
//   step     in   1  a rising edge advances one state while paused
//   seg      out  7  {g,f,e,d,c,b,a}, active high, registered
//   beat     out  1  one-cycle pulse on entry to LUB, registered
//   state_o  out  2  current state: REST=0, LUB=1, GAP=2, DUB=3
// -----------------------------------------------------------------------------
module heartbeat_seq #(
  parameter int SHIFT      = 20,
  parameter int REST_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] speed,
  input  logic       pause,
  input  logic       step,
  output logic [6:0] seg,
  output logic       beat,
  output logic [1:0] state_o
);

  localparam int CW = 4 + SHIFT;
  localparam int DW = (REST_TICKS > 1) ? $clog2(REST_TICKS) : 1;
  localparam logic [DW-1:0] REST_LAST = DW'(REST_TICKS - 1);

  typedef enum logic [1:0] {
    REST = 2'd0,
    LUB  = 2'd1,
    GAP  = 2'd2,
    DUB  = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   limit;
  logic [DW-1:0]   dwell;
  logic            step_q;
  logic            run;
  logic            rise;
  logic            stepped;
  logic            tick;
  logic            dwell_last;
  logic            advance;

  // Display pattern shown for each state.
  function automatic logic [6:0] pattern(input state_t s);
    logic [6:0] p;
    case (s)
      REST:    p = 7'b0001000;  // flat line (d)
      LUB:     p = 7'b0111111;  // big O
      GAP:     p = 7'b1000000;  // g
      DUB:     p = 7'b1100011;  // small top o
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  // Ring order of the rhythm.
  function automatic state_t succ(input state_t s);
    state_t n;
    case (s)
      REST:    n = LUB;
      LUB:     n = GAP;
      GAP:     n = DUB;
      DUB:     n = REST;
      default: n = REST;
    endcase
    return n;
  endfunction

  // Tick detection, step edge detection and next-state selection.
  always_comb begin
    limit      = {speed, {SHIFT{1'b1}}};
    run        = ena & ~pause;
    rise       = step & ~step_q;
    stepped    = ena & pause & rise;
    // ">=" rather than "==" so lowering speed mid-count ticks at once
    // instead of wrapping through the whole counter range.
    tick       = run & (cnt >= limit);
    if (state == REST) begin
      dwell_last = (dwell == REST_LAST);
    end else begin
      dwell_last = 1'b1;
    end
    advance    = (tick & dwell_last) | stepped;
    if (advance) begin
      next_state = succ(state);
    end else begin
      next_state = state;
    end
  end

  // Sequencer state, prescaler, dwell counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= REST;
      cnt    <= {CW{1'b0}};
      dwell  <= {DW{1'b0}};
      step_q <= 1'b0;
      seg    <= 7'b0000000;
      beat   <= 1'b0;
    end else begin
      step_q <= step;
      if (ena) begin
        if (stepped) begin
          cnt   <= {CW{1'b0}};
          dwell <= {DW{1'b0}};
        end else if (run) begin
          if (tick) begin
            cnt <= {CW{1'b0}};
            if (dwell_last) begin
              dwell <= {DW{1'b0}};
            end else begin
              dwell <= dwell + DW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        state <= next_state;
        // Driven from next_state so the pattern changes on the same edge
        // as the state.
        seg   <= pattern(next_state);
        beat  <= advance & (next_state == LUB);
      end else begin
        seg  <= 7'b0000000;
        beat <= 1'b0;
      end
    end
  end

  assign state_o = state;

endmodule
